digit_template_matcher: RTL and testbench



---
 rtl/digit_template_matcher_if.sv | 25 ++
 rtl/digit_template_matcher.sv | 83 ++++++++
 tb/tb_digit_template_matcher.sv | 131 +++++++++++++
 3 files changed

// File: rtl/digit_template_matcher_if.sv
// digit_template_matcher_if: bus between the matcher, template ROM bank, capture buffer and result logic
interface digit_template_matcher_if #(
   parameter int ADDR_W  = 12,
   parameter int SCORE_W = 12
);
   logic               start;
   logic               busy;
   logic               done;
   logic [3:0]         tpl_sel;
   logic               rom_ce;
   logic [ADDR_W-1:0]  rom_ad;
   logic               rom_dout;
   logic [ADDR_W-1:0]  smp_ad;
   logic               smp_dout;
   logic [3:0]         best_digit;
   logic [SCORE_W-1:0] best_score;
   modport master (
      input  start, rom_dout, smp_dout,
      output busy, done, tpl_sel, rom_ce, rom_ad, smp_ad, best_digit, best_score
   );
   modport slave (
      output start, rom_dout, smp_dout,
      input  busy, done, tpl_sel, rom_ce, rom_ad, smp_ad, best_digit, best_score
   );
endinterface

// File: rtl/digit_template_matcher.sv
// digit_template_matcher: scores the capture bitmap against each template ROM and keeps the best match
module digit_template_matcher #(
   parameter int ADDR_W   = 12,
   parameter int TPL_BITS = 2500,
   parameter int NUM_TPL  = 10,
   parameter int SCORE_W  = 12
) (
   input logic clk,
   input logic reset,
   digit_template_matcher_if.master bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] DRAIN1 = 3'd2;
   localparam logic [2:0] DRAIN2 = 3'd3;
   localparam logic [2:0] UPDATE = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(TPL_BITS - 1);
   localparam logic [3:0] LAST_TPL = 4'(NUM_TPL - 1);
   logic [2:0]         state;
   logic [ADDR_W-1:0]  addr;
   logic [3:0]         tpl_sel;
   logic [3:0]         best_digit;
   logic [SCORE_W-1:0] best_score;
   logic [SCORE_W-1:0] acc;
   logic               valid;
   // sequencer: walks addresses per template, drains the read pipeline, then keeps the best score
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         tpl_sel    <= '0;
         best_digit <= '0;
         best_score <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state      <= RUN;
               addr       <= '0;
               tpl_sel    <= '0;
               best_digit <= '0;
               best_score <= '0;
            end
            RUN: if (addr == LAST_AD) state <= DRAIN1;
                 else addr <= addr + 1'b1;
            DRAIN1: state <= DRAIN2;
            DRAIN2: state <= UPDATE;
            UPDATE: begin
               if (acc > best_score || tpl_sel == 4'd0) begin
                  best_score <= acc;
                  best_digit <= tpl_sel;
               end
               if (tpl_sel == LAST_TPL) state <= DONE;
               else begin
                  tpl_sel <= tpl_sel + 4'd1;
                  addr    <= '0;
                  state   <= RUN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   // compare pipeline: read data arrives one cycle after issue, agreeing bits are counted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         acc   <= '0;
      end else begin
         valid <= state == RUN;
         if ((state == IDLE && bus.start) || state == UPDATE) acc <= '0;
         else if (valid) acc <= acc + SCORE_W'(bus.rom_dout == bus.smp_dout);
      end
   end
   assign bus.busy       = state == RUN || state == DRAIN1 || state == DRAIN2 || state == UPDATE;
   assign bus.done       = state == DONE;
   assign bus.rom_ce     = state == RUN;
   assign bus.rom_ad     = addr;
   assign bus.smp_ad     = addr;
   assign bus.tpl_sel    = tpl_sel;
   assign bus.best_digit = best_digit;
   assign bus.best_score = best_score;
endmodule

// File: tb/tb_digit_template_matcher.sv
// tb_digit_template_matcher: directed runs against behavioural template/capture ROMs
module tb_digit_template_matcher;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   mode = 1;
   int   checks = 0;
   int   failures = 0;
   int   mon_bad = 0;
   int   done_cnt = 0;
   int   ce_low = 0;
   int   cov [10][2500];
   logic [3:0] prev_sel = 4'd0;
   logic prev_busy = 1'b0;

   digit_template_matcher_if #(.ADDR_W(12), .SCORE_W(12)) bus ();

   digit_template_matcher #(.ADDR_W(12), .TPL_BITS(2500), .NUM_TPL(10), .SCORE_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic tpl_bit(input int m, input int k, input int a);
      case (m)
         1:       return (k == 8) ? (a == 1234) : (k % 2 == 1);
         2:       return a < 100 * k;
         default: return (k == 2 || k == 5) ? (a % 3 == 0) : ((a % 3 == 0) ^ (a < 10 * (k + 1)));
      endcase
   endfunction

   function automatic logic smp_bit(input int m, input int a);
      case (m)
         1:       return a == 1234;
         2:       return 1'b0;
         default: return a % 3 == 0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.rom_ce) bus.rom_dout <= tpl_bit(mode, int'(bus.tpl_sel), int'(bus.rom_ad));
      bus.smp_dout <= smp_bit(mode, int'(bus.smp_ad));
   end

   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.rom_ad !== bus.smp_ad) mon_bad++;
      if (bus.rom_ce === 1'b1) begin
         if (bus.rom_ad >= 12'd2500 || bus.tpl_sel > 4'd9) mon_bad++;
         else cov[bus.tpl_sel][bus.rom_ad]++;
      end
      if (bus.tpl_sel !== prev_sel && reset === 1'b0) begin
         if (!((bus.tpl_sel == prev_sel + 4'd1 && ce_low >= 3 && prev_busy) ||
               (bus.tpl_sel == 4'd0 && !prev_busy))) mon_bad++;
      end
      ce_low = (bus.rom_ce === 1'b1) ? 0 : ce_low + 1;
      prev_sel = bus.tpl_sel;
      prev_busy = bus.busy;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic do_run(input int m, input logic [3:0] ed, input logic [11:0] es, input bit rep, input string tag);
      int n;
      int bad;
      mode = m;
      for (int t = 0; t < 10; t++) for (int a = 0; a < 2500; a++) cov[t][a] = 0;
      mon_bad = 0;
      done_cnt = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      chk({tag, "_first"}, {bus.busy, bus.rom_ce, bus.tpl_sel, bus.rom_ad, bus.best_digit, bus.best_score},
          {1'b1, 1'b1, 4'd0, 12'd0, 4'd0, 12'd0});
      while (bus.done !== 1'b1 && n < 30000) begin
         bus.start = rep && (n == 10 || n == 5000);
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, 64'(n), 64'd25031);
      chk({tag, "_done_busy"}, {bus.done, bus.busy}, {1'b1, 1'b0});
      chk({tag, "_digit"}, 64'(bus.best_digit), 64'(ed));
      chk({tag, "_score"}, 64'(bus.best_score), 64'(es));
      @(negedge clk);
      chk({tag, "_done_pulse"}, {bus.done, bus.busy}, {1'b0, 1'b0});
      repeat (5) @(negedge clk);
      chk({tag, "_hold"}, {bus.best_digit, bus.best_score}, {ed, es});
      chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      chk({tag, "_monitor"}, 64'(mon_bad), 64'd0);
      bad = 0;
      for (int t = 0; t < 10; t++) for (int a = 0; a < 2500; a++) if (cov[t][a] != 1) bad++;
      chk({tag, "_addr_cover"}, 64'(bad), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      @(negedge clk);
      chk("reset_vals", {bus.busy, bus.done, bus.rom_ce, bus.rom_ad, bus.smp_ad, bus.tpl_sel, bus.best_digit, bus.best_score}, 64'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_busy", {bus.busy, bus.done, bus.rom_ce}, 64'd0);
      do_run(1, 4'd8, 12'd2500, 1'b1, "unique8_repulse");
      do_run(3, 4'd2, 12'd2500, 1'b0, "tie2_5");
      mode = 2;
      done_cnt = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (11999) @(negedge clk);
      chk("mid_busy", {bus.busy, bus.best_digit, bus.best_score}, {1'b1, 4'd0, 12'd2500});
      #1 reset = 1'b1;
      #1 chk("rst_async", {bus.busy, bus.done, bus.rom_ce, bus.rom_ad, bus.smp_ad, bus.tpl_sel, bus.best_digit, bus.best_score}, 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_no_done", 64'(done_cnt), 64'd0);
      chk("rst_idle", {bus.busy, bus.rom_ce}, 64'd0);
      do_run(2, 4'd0, 12'd2500, 1'b0, "ramp_after_reset");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
